mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
// - MIPS MEM stage, directly downstream of execution: consumes aluRes/destReg/zero/branchdst plus MEM/WB control.
// - Performs load/store over a req/ack data-memory handshake, stalls upstream while waiting.
// - Resolves branches (pcSrc) and emits one registered MEM/WB result per accepted instruction.
// PARAMETERS
// - DATA_W   32  data/address width
// - PC_W     30  word-address width of branch target
// - MAX_WAIT 16  cycles in ACCESS without memAck before bus-timeout abort (>=1)
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous active-low reset
// - inValid      in   1       EX result valid; held by upstream while stall=1
// - aluRes       in   DATA_W  ALU result / memory byte address
// - storeData    in   DATA_W  readData2 forwarded for stores
// - destReg      in   5       write-back register index
// - zero         in   1       ALU zero flag
// - branchdst    in   PC_W    branch target (word address)
// - branch, memRead, memWrite, regWrite, memToReg  in 1 each  control bits
// - stall        out  1       1 = upstream must hold; inputs ignored
// - pcSrc        out  1       registered: branch taken (branch & zero)
// - branchTarget out  PC_W    registered branchdst
// - memReq       out  1       memory request, registered
// - memWe        out  1       1 = write, 0 = read; valid with memReq
// - memAddr      out  DATA_W  word-aligned byte address; valid with memReq
// - memWdata     out  DATA_W  store data; valid with memReq & memWe
// - memRdata     in   DATA_W  load data; sampled when memAck=1
// - memAck       in   1       single-cycle completion pulse
// - wbValid      out  1       one-cycle pulse: MEM/WB result valid
// - wbData       out  DATA_W  memToReg ? loaded data : aluRes
// - wbDest       out  5       destReg of result
// - wbRegWrite   out  1       regWrite, forced 0 on any error
// - alignErr     out  1       one-cycle pulse with wbValid: aluRes[1:0]!=0 on mem op
// - busErr       out  1       one-cycle pulse with wbValid: MAX_WAIT expired
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, all outputs 0 incl. memReq, stall, wbValid, errors, counter.
// - States: IDLE, ACCESS. stall = (state==ACCESS), purely from state register.
// - IDLE, inValid=1, no mem op: next edge wbValid=1, wbData=aluRes, wbDest, wbRegWrite=regWrite,
//   pcSrc=branch&zero, branchTarget=branchdst. Latency 1 cycle.
// - IDLE, inValid=1, memRead|memWrite, aluRes[1:0]==0: latch addr/wdata/ctrl; next edge state=ACCESS,
//   memReq=1, memWe=memWrite, waitCnt=0; wbValid=0; pcSrc=0.
// - IDLE, mem op misaligned: no request; next edge wbValid=1, alignErr=1, wbRegWrite=0, wbData=aluRes.
// - memRead & memWrite both 1: treated as write.
// - ACCESS: memReq/memWe/memAddr/memWdata held stable until ack or timeout; waitCnt++ each cycle.
// - ACCESS & memAck: next edge memReq=0, state=IDLE, wbValid=1; load: wbData=memRdata when memToReg,
//   else aluRes; store: wbRegWrite=0. Min load/store latency 2 cycles (ack in first ACCESS cycle).
// - ACCESS & waitCnt==MAX_WAIT-1 & !memAck: next edge memReq=0, state=IDLE, wbValid=1, busErr=1, wbRegWrite=0.
// - memAck and timeout in same cycle: ack wins, no busErr.
// - memAck while not in ACCESS: ignored. inValid while stall=1: ignored (no capture).
// - wbValid/alignErr/busErr/pcSrc are single-cycle pulses; cleared next edge unless a new result is produced.
// - Instruction accepted in the same cycle ACCESS ends: not possible (stall=1 that cycle); next accept at IDLE.
// - Reset during ACCESS: memReq drops asynchronously; outstanding transaction abandoned, no wbValid.
// - Arithmetic: waitCnt width $clog2(MAX_WAIT+1), saturates never (exit at MAX_WAIT-1); no address arithmetic.
// STRUCTURE
// - mips_pkg: state encoding (MEM_IDLE, MEM_ACCESS), DATA_W/PC_W defaults, control-bit field constants.
// - Sub-module mem_wait_timer: clear/enable counter, expired flag at MAX_WAIT-1.
// - Remainder: FSM, request registers, MEM/WB output register in mem_access_stage.
// TESTING
// - ALU op: inValid, aluRes=0x0000_0040, regWrite=1, destReg=5 -> next cycle wbValid=1, wbData=0x40, wbDest=5, stall=0.
// - Branch: branch=1, zero=1, branchdst=0x100 -> next cycle pcSrc=1, branchTarget=0x100; zero=0 -> pcSrc=0.
// - Load, ack after 3 cycles, memRdata=0xDEADBEEF, aluRes=0x80 -> memReq=1 memAddr=0x80 memWe=0, stall=1 for
//   4 cycles, then wbValid=1 wbData=0xDEADBEEF wbRegWrite=1, memReq=0.
// - Store, ack in first ACCESS cycle, aluRes=0x10, storeData=0x1234 -> memWe=1 memWdata=0x1234; wbValid=1 wbRegWrite=0.
// - Misaligned load aluRes=0x82 -> memReq never 1; next cycle wbValid=1 alignErr=1 wbRegWrite=0.
// - No ack, MAX_WAIT=16 -> memReq high 16 cycles, then busErr=1 wbValid=1; repeat with ack on cycle 16 -> no busErr;
//   rst_n low mid-ACCESS -> memReq=0 immediately, no wbValid after release.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Purpose  : Shared types and constants for the MIPS MEM stage: FSM state
//            encoding, default bus widths, control-bit field positions and a
//            small alignment helper.
// Revision : 1.0  initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int PC_W_DEF     = 30;
    localparam int MAX_WAIT_DEF = 16;
    localparam int REG_IDX_W    = 5;

    // Bit positions of the EX->MEM control bundle, for callers that carry it packed.
    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_W        = 5;

    typedef enum logic [0:0] {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage : mem_access_stage_pkg
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : Data-memory request/acknowledge bus between the MEM stage
//            (master) and the data memory (slave).
// Signals  : memReq   master->slave  request, held until memAck or abort
//            memWe    master->slave  1 = write, 0 = read
//            memAddr  master->slave  word-aligned byte address
//            memWdata master->slave  store data
//            memRdata slave->master  load data, valid with memAck
//            memAck   slave->master  single-cycle completion pulse
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              memReq;
    logic              memWe;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memAck;

    modport master (
        output memReq, memWe, memAddr, memWdata,
        input  memRdata, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata,
        output memRdata, memAck
    );
endinterface : mem_access_stage_if
`default_nettype wire

// File: rtl/mem_access_stage_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Purpose  : Counts cycles spent waiting for a memory acknowledge.
// Ports    : clk       rising-edge clock
//            rst_n     asynchronous active-low reset
//            i_clear   synchronous clear to zero (has priority)
//            i_enable  increment once per cycle
//            o_expired count has reached MAX_WAIT-1
// Revision : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_cnt;

    // The owner leaves ACCESS on the expiry cycle, so the count never needs
    // to saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CNT_W'(MAX_WAIT - 1));

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MIPS MEM stage. Accepts one EX result at a time, performs a
//            load/store over the req/ack data-memory bus (stalling upstream
//            while waiting), resolves branches and emits one registered
//            MEM/WB result per accepted instruction.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            i_inValid ..        EX result and MEM/WB control bits
//            o_stall             1 while a memory access is outstanding
//            o_pcSrc/o_branchTarget  registered branch decision and target
//            o_wb*               MEM/WB result (o_wbValid is a 1-cycle pulse)
//            o_alignErr/o_busErr 1-cycle error pulses, coincident with o_wbValid
//            mem_bus             data-memory request/ack bus (master side)
// Revision : 1.0  initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PC_W     = PC_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_inValid,
    input  wire logic [DATA_W-1:0]    i_aluRes,
    input  wire logic [DATA_W-1:0]    i_storeData,
    input  wire logic [REG_IDX_W-1:0] i_destReg,
    input  wire logic                 i_zero,
    input  wire logic [PC_W-1:0]      i_branchdst,
    input  wire logic                 i_branch,
    input  wire logic                 i_memRead,
    input  wire logic                 i_memWrite,
    input  wire logic                 i_regWrite,
    input  wire logic                 i_memToReg,
    output logic                      o_stall,
    output logic                      o_pcSrc,
    output logic [PC_W-1:0]           o_branchTarget,
    output logic                      o_wbValid,
    output logic [DATA_W-1:0]         o_wbData,
    output logic [REG_IDX_W-1:0]      o_wbDest,
    output logic                      o_wbRegWrite,
    output logic                      o_alignErr,
    output logic                      o_busErr,
    mem_access_stage_if.master        mem_bus
);

    mem_state_t r_state;
    mem_state_t w_state_nxt;

    // Request held for the duration of ACCESS
    logic [DATA_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_we;
    logic [REG_IDX_W-1:0] r_dest;
    logic                 r_regWrite;
    logic                 r_memToReg;

    // MEM/WB output register
    logic                 r_wbValid;
    logic [DATA_W-1:0]    r_wbData;
    logic [REG_IDX_W-1:0] r_wbDest;
    logic                 r_wbRegWrite;
    logic                 r_alignErr;
    logic                 r_busErr;
    logic                 r_pcSrc;
    logic [PC_W-1:0]      r_branchTarget;

    logic w_in_access;
    logic w_accept;
    logic w_memOp;
    logic w_start;
    logic w_ack;
    logic w_timeout;
    logic w_expired;

    assign w_in_access = (r_state == MEM_ACCESS);
    assign w_accept    = (r_state == MEM_IDLE) && i_inValid;
    assign w_memOp     = i_memRead || i_memWrite;
    assign w_start     = w_accept && w_memOp && is_word_aligned(i_aluRes[1:0]);
    assign w_ack       = w_in_access && mem_bus.memAck;
    // An acknowledge arriving on the expiry cycle still completes normally.
    assign w_timeout   = w_in_access && w_expired && !mem_bus.memAck;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (!w_in_access),
        .i_enable  (w_in_access),
        .o_expired (w_expired)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MEM_IDLE: begin
                if (w_start) begin
                    w_state_nxt = MEM_ACCESS;
                end
            end
            MEM_ACCESS: begin
                if (w_ack || w_timeout) begin
                    w_state_nxt = MEM_IDLE;
                end
            end
            default: w_state_nxt = MEM_IDLE;
        endcase
    end

    // ------------------------------------------------------ request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_dest     <= '0;
            r_regWrite <= 1'b0;
            r_memToReg <= 1'b0;
        end else if (w_start) begin
            r_addr     <= i_aluRes;
            r_wdata    <= i_storeData;
            r_we       <= i_memWrite;   // read+write together resolves to write
            r_dest     <= i_destReg;
            r_regWrite <= i_regWrite;
            r_memToReg <= i_memToReg;
        end
    end

    // ------------------------------------------------------- MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbValid      <= 1'b0;
            r_wbData       <= '0;
            r_wbDest       <= '0;
            r_wbRegWrite   <= 1'b0;
            r_alignErr     <= 1'b0;
            r_busErr       <= 1'b0;
            r_pcSrc        <= 1'b0;
            r_branchTarget <= '0;
        end else begin
            // Pulses fall unless a new result is produced this edge.
            r_wbValid  <= 1'b0;
            r_alignErr <= 1'b0;
            r_busErr   <= 1'b0;
            r_pcSrc    <= 1'b0;
            if (w_accept && !w_start) begin
                // Non-memory op or misaligned memory op: single-cycle result.
                r_wbValid      <= 1'b1;
                r_wbData       <= i_aluRes;
                r_wbDest       <= i_destReg;
                r_branchTarget <= i_branchdst;
                if (w_memOp) begin
                    r_wbRegWrite <= 1'b0;
                    r_alignErr   <= 1'b1;
                end else begin
                    r_wbRegWrite <= i_regWrite;
                    r_pcSrc      <= i_branch && i_zero;
                end
            end else if (w_ack) begin
                r_wbValid    <= 1'b1;
                r_wbData     <= (!r_we && r_memToReg) ? mem_bus.memRdata : r_addr;
                r_wbDest     <= r_dest;
                r_wbRegWrite <= r_regWrite && !r_we;
            end else if (w_timeout) begin
                r_wbValid    <= 1'b1;
                r_wbData     <= r_addr;
                r_wbDest     <= r_dest;
                r_wbRegWrite <= 1'b0;
                r_busErr     <= 1'b1;
            end
        end
    end

    // memReq is the ACCESS state itself, so it drops with the async reset.
    assign mem_bus.memReq   = w_in_access;
    assign mem_bus.memWe    = r_we;
    assign mem_bus.memAddr  = r_addr;
    assign mem_bus.memWdata = r_wdata;

    assign o_stall        = w_in_access;
    assign o_pcSrc        = r_pcSrc;
    assign o_branchTarget = r_branchTarget;
    assign o_wbValid      = r_wbValid;
    assign o_wbData       = r_wbData;
    assign o_wbDest       = r_wbDest;
    assign o_wbRegWrite   = r_wbRegWrite;
    assign o_alignErr     = r_alignErr;
    assign o_busErr       = r_busErr;

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Scoreboard bench for mem_access_stage. A driver issues directed
//            and random instructions and pushes the expected MEM/WB result
//            (including the edge on which it must appear); a memory model
//            answers requests with planned delays; a monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int MW = 16;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        rw;
        logic        ae;
        logic        be;
        logic        pc;
        logic [29:0] bt;
        bit          chk_bt;
        int          edge_no;
    } wb_exp_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_plan_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, zero, branch, memRead, memWrite, regWrite, memToReg;
    logic [31:0] aluRes, storeData;
    logic [4:0]  destReg;
    logic [29:0] branchdst;
    logic        stall, pcSrc, wbValid, wbRegWrite, alignErr, busErr;
    logic [29:0] branchTarget;
    logic [31:0] wbData;
    logic [4:0]  wbDest;

    wb_exp_t   exp_q[$];
    mem_plan_t plan_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        cycle_cnt = 0;
    bit        junk_ack_en = 1'b0;

    mem_access_stage_if #(.DATA_W(32)) mbus ();

    mem_access_stage #(
        .DATA_W(32), .PC_W(30), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_inValid(inValid), .i_aluRes(aluRes), .i_storeData(storeData),
        .i_destReg(destReg), .i_zero(zero), .i_branchdst(branchdst),
        .i_branch(branch), .i_memRead(memRead), .i_memWrite(memWrite),
        .i_regWrite(regWrite), .i_memToReg(memToReg),
        .o_stall(stall), .o_pcSrc(pcSrc), .o_branchTarget(branchTarget),
        .o_wbValid(wbValid), .o_wbData(wbData), .o_wbDest(wbDest),
        .o_wbRegWrite(wbRegWrite), .o_alignErr(alignErr), .o_busErr(busErr),
        .mem_bus(mbus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- monitor
    always @(negedge clk) begin : monitor
        wb_exp_t e;
        if (rst_n === 1'b1) begin
            if (wbValid) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_edge", 64'(cycle_cnt), 64'(e.edge_no));
                    check("wb_data", wbData, e.data);
                    check("wb_dest", wbDest, e.dest);
                    check("wb_regwrite", wbRegWrite, e.rw);
                    check("align_err", alignErr, e.ae);
                    check("bus_err", busErr, e.be);
                    check("pc_src", pcSrc, e.pc);
                    if (e.chk_bt) check("branch_target", branchTarget, e.bt);
                end
            end else if (alignErr || busErr || pcSrc) begin
                check("pulse_without_wb", {alignErr, busErr, pcSrc}, 0);
            end
        end
    end

    // ---------------------------------------------------- memory model
    always @(negedge clk) begin : responder
        static int        rcyc = 0;
        static mem_plan_t cur;
        if (rst_n !== 1'b1) begin
            rcyc         = 0;
            mbus.memAck   = 1'b0;
            mbus.memRdata = '0;
        end else if (mbus.memReq) begin
            if (rcyc == 0) begin
                if (plan_q.size() == 0) begin
                    check("unplanned_request", 1, 0);
                    cur = '{delay: 1000, rdata: 0, addr: mbus.memAddr, we: mbus.memWe, wdata: mbus.memWdata};
                end else begin
                    cur = plan_q.pop_front();
                end
            end
            check("mem_addr", mbus.memAddr, cur.addr);
            check("mem_we", mbus.memWe, cur.we);
            if (cur.we) check("mem_wdata", mbus.memWdata, cur.wdata);
            mbus.memAck   = (rcyc == cur.delay);
            mbus.memRdata = (rcyc == cur.delay) ? cur.rdata : $urandom;
            rcyc++;
        end else begin
            rcyc          = 0;
            mbus.memAck   = junk_ack_en && ($urandom_range(0, 3) == 0);
            mbus.memRdata = $urandom;
        end
    end

    // ---------------------------------------------------------- driver
    // Called at a negedge. Presents one instruction, records what the stage
    // must produce, then keeps garbage on the inputs while the stage stalls.
    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst,
                         input logic z, input logic [29:0] bd, input logic br, input logic mr,
                         input logic mw, input logic rw, input logic m2r,
                         input int delay, input logic [31:0] rd);
        int        guard;
        wb_exp_t   e;
        mem_plan_t p;
        guard = 0;
        while (stall && guard < MW + 10) begin
            @(negedge clk);
            guard++;
        end
        if (stall) check("stall_before_issue_timeout", 1, 0);
        inValid = 1'b1; aluRes = alu; storeData = sd; destReg = dst; zero = z;
        branchdst = bd; branch = br; memRead = mr; memWrite = mw;
        regWrite = rw; memToReg = m2r;

        e = '{data: alu, dest: dst, rw: 1'b0, ae: 1'b0, be: 1'b0, pc: 1'b0,
              bt: bd, chk_bt: 1'b0, edge_no: cycle_cnt + 1};
        if (!(mr || mw)) begin
            e.rw = rw;
            e.pc = br && z;
            e.chk_bt = 1'b1;
        end else if (alu[1:0] != 2'b00) begin
            e.ae = 1'b1;
        end else begin
            p = '{delay: delay, rdata: rd, addr: alu, we: mw, wdata: sd};
            plan_q.push_back(p);
            if (delay < MW) begin
                e.data    = (!mw && m2r) ? rd : alu;
                e.rw      = mw ? 1'b0 : rw;
                e.edge_no = cycle_cnt + 1 + delay + 1;
            end else begin
                e.be      = 1'b1;
                e.edge_no = cycle_cnt + 1 + MW;
            end
        end
        exp_q.push_back(e);

        @(negedge clk);
        guard = 0;
        while (stall && guard < MW + 10) begin
            inValid = 1'b1; aluRes = $urandom; storeData = $urandom; destReg = 5'($urandom);
            zero = 1'($urandom); branch = 1'($urandom); memRead = 1'($urandom);
            memWrite = 1'($urandom); regWrite = 1'($urandom); memToReg = 1'($urandom);
            branchdst = 30'($urandom);
            @(negedge clk);
            guard++;
        end
        if (stall) check("access_end_timeout", 1, 0);
        inValid = 1'b0;
    endtask

    initial begin : stim
        int guard;
        rst_n = 1'b0; inValid = 1'b0; aluRes = '0; storeData = '0; destReg = '0;
        zero = 1'b0; branchdst = '0; branch = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        regWrite = 1'b0; memToReg = 1'b0;
        #3;
        check("rst_stall", stall, 0);
        check("rst_memReq", mbus.memReq, 0);
        check("rst_wbValid", wbValid, 0);
        check("rst_pcSrc", pcSrc, 0);
        check("rst_errs", {alignErr, busErr}, 0);
        check("rst_wbData", wbData, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(32'h40, 0, 5'd5, 0, 30'h0, 0, 0, 0, 1, 0, 0, 0);              // ALU op
        issue(32'h0, 0, 5'd0, 1, 30'h100, 1, 0, 0, 0, 0, 0, 0);             // branch taken
        issue(32'h4, 0, 5'd0, 0, 30'h100, 1, 0, 0, 0, 0, 0, 0);             // branch not taken
        issue(32'h80, 0, 5'd7, 0, 30'h0, 0, 1, 0, 1, 1, 3, 32'hDEADBEEF);   // load, ack after 3
        issue(32'h10, 32'h1234, 5'd3, 0, 30'h0, 0, 0, 1, 1, 0, 0, 0);       // store, ack at once
        issue(32'h82, 0, 5'd4, 0, 30'h0, 0, 1, 0, 1, 1, 0, 0);              // misaligned load
        issue(32'h20, 0, 5'd8, 0, 30'h0, 0, 1, 0, 1, 1, 99, 32'h5555);      // timeout
        issue(32'h24, 0, 5'd9, 0, 30'h0, 0, 1, 0, 1, 1, MW - 1, 32'hA5A5);  // ack on last cycle
        issue(32'h28, 32'h77, 5'd10, 0, 30'h0, 0, 1, 1, 1, 1, 1, 32'h99);   // read+write -> write

        // Reset in the middle of an access abandons it without a result
        fork
            issue(32'h44, 0, 5'd9, 0, 30'h0, 0, 1, 0, 1, 1, 99, 0);
            begin
                repeat (4) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("midrst_memReq", mbus.memReq, 0);
                check("midrst_stall", stall, 0);
                check("midrst_wbValid", wbValid, 0);
            end
        join
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(32'h40, 0, 5'd6, 0, 30'h0, 0, 0, 0, 1, 0, 0, 0);

        // Random traffic
        junk_ack_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int          op, dly;
            op = $urandom_range(0, 3);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case ($urandom_range(0, 5))
                0:       dly = MW - 1;
                1:       dly = MW + $urandom_range(0, 3);
                default: dly = $urandom_range(0, 5);
            endcase
            issue(a, $urandom, 5'($urandom), 1'($urandom), 30'($urandom), 1'($urandom),
                  op == 1 || op == 3, op == 2 || op == 3, 1'($urandom), 1'($urandom),
                  dly, $urandom);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("exp_queue_drained", 64'(exp_q.size()), 0);
        check("plan_queue_drained", 64'(plan_q.size()), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_mem_access_stage
`default_nettype wire
